// File: rtl/event_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module      : event_pattern_seq
// Description : Button-driven phase sequencer that animates one of four
//               patterns across a row of seven-segment digits.
// Revision    : 1.0 - initial release
// ============================================================================
module event_pattern_seq #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 4,
  parameter int STICKY     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    button_inp,
  input  logic [1:0]              mode,
  output logic [NUM_DIGITS*7-1:0] seg_bus,
  output logic                    active,
  output logic                    step_pulse
);

  localparam int c_div_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_pos_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(TICK_DIV - 1);
  localparam logic [c_pos_w-1:0] c_pos_last = c_pos_w'(NUM_DIGITS - 1);
  localparam logic [6:0] c_seg_g   = 7'h40;
  localparam logic [6:0] c_seg_f   = 7'h20;
  localparam logic [6:0] c_seg_all = 7'h7F;

  // The state register is the run flag itself.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 btn_q;
  logic [1:0]           mode_q;
  logic [c_div_w-1:0]   div_q, div_d;
  logic [c_pos_w-1:0]   pos_q, pos_d;
  logic                 step_q, step_d;
  logic                 w_press;
  logic                 w_run_next;
  logic [NUM_DIGITS*7-1:0] w_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      btn_q   <= 1'b0;
      mode_q  <= 2'b00;
      div_q   <= '0;
      pos_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= button_inp;
      mode_q  <= mode;
      div_q   <= div_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    pos_d      = '0;
    step_d     = 1'b0;
    w_press    = button_inp & ~btn_q;
    w_run_next = button_inp;
    if (STICKY != 0) begin
      w_run_next = (state_q == ST_RUN) ^ w_press;
    end
    state_d = w_run_next ? ST_RUN : ST_IDLE;
    // Counting continues only while staying in RUN with a stable mode;
    // entry, release and mode changes all leave div/pos at zero.
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && (mode == mode_q)) begin
      if (div_q == c_div_last) begin
        step_d = 1'b1;
        pos_d  = (pos_q == c_pos_last) ? '0 : pos_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
        pos_d = pos_q;
      end
    end
  end

  always_comb begin
    w_seg = '0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        case (mode_q)
          2'b00:   w_seg[7*i +: 7] = pos_q[0] ? c_seg_f : c_seg_g;
          2'b01:   w_seg[7*i +: 7] = (int'(pos_q) == i) ? c_seg_g : 7'h00;
          2'b10:   w_seg[7*i +: 7] = (i <= int'(pos_q)) ? c_seg_g : 7'h00;
          default: w_seg[7*i +: 7] = pos_q[0] ? 7'h00 : c_seg_all;
        endcase
      end
    end
  end

  assign seg_bus    = w_seg;
  assign active     = (state_q == ST_RUN);
  assign step_pulse = step_q;

endmodule
`default_nettype wire

// File: tb/tb_event_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_pattern_seq
// Description : Randomized bench for event_pattern_seq across three parameter
//               sets, checked against an elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_pattern_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        button_inp;
  logic [1:0]  mode;
  logic [55:0] seg0;
  logic [34:0] seg1;
  logic [55:0] seg2;
  logic [2:0]  act;
  logic [2:0]  stp;

  int n_chk = 0;
  int n_err = 0;

  int ND [3] = '{8, 5, 8};
  int TD [3] = '{4, 3, 4};
  int ST [3] = '{0, 0, 1};

  logic     m_run  [3];
  logic     m_btn  [3];
  logic     m_step [3];
  int       m_el   [3];
  logic [1:0] m_mode;

  always #5 clk = ~clk;

  event_pattern_seq #(.NUM_DIGITS(8), .TICK_DIV(4), .STICKY(0)) u_dut0 (
    .clk(clk), .rst(rst), .button_inp(button_inp), .mode(mode),
    .seg_bus(seg0), .active(act[0]), .step_pulse(stp[0]));
  event_pattern_seq #(.NUM_DIGITS(5), .TICK_DIV(3), .STICKY(0)) u_dut1 (
    .clk(clk), .rst(rst), .button_inp(button_inp), .mode(mode),
    .seg_bus(seg1), .active(act[1]), .step_pulse(stp[1]));
  event_pattern_seq #(.NUM_DIGITS(8), .TICK_DIV(4), .STICKY(1)) u_dut2 (
    .clk(clk), .rst(rst), .button_inp(button_inp), .mode(mode),
    .seg_bus(seg2), .active(act[2]), .step_pulse(stp[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pattern derived from elapsed run time: phase = elapsed / TICK_DIV mod N.
  function automatic logic [63:0] exp_seg(input int k);
    logic [63:0] v;
    int          p;
    logic [6:0]  d;
    v = '0;
    if (m_run[k]) begin
      p = (m_el[k] / TD[k]) % ND[k];
      for (int i = 0; i < ND[k]; i++) begin
        case (m_mode)
          2'd0:    d = (p % 2 == 1) ? 7'h20 : 7'h40;
          2'd1:    d = (i == p) ? 7'h40 : 7'h00;
          2'd2:    d = (i <= p) ? 7'h40 : 7'h00;
          default: d = (p % 2 == 1) ? 7'h00 : 7'h7F;
        endcase
        v[7*i +: 7] = d;
      end
    end
    return v;
  endfunction

  task automatic model_edge();
    logic run_n;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_run[k] = 1'b0; m_btn[k] = 1'b0; m_step[k] = 1'b0; m_el[k] = 0;
      end else begin
        run_n = (ST[k] != 0) ? (m_run[k] ^ (button_inp & ~m_btn[k])) : button_inp;
        if (m_run[k] && run_n && (mode == m_mode)) begin
          m_el[k]++;
          m_step[k] = (m_el[k] % TD[k] == 0);
        end else begin
          m_el[k]   = 0;
          m_step[k] = 1'b0;
        end
        m_run[k] = run_n;
        m_btn[k] = button_inp;
      end
    end
    m_mode = rst ? 2'b00 : mode;
  endtask

  task automatic cycle();
    logic [63:0] got;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      got = (k == 0) ? 64'(seg0) : (k == 1) ? 64'(seg1) : 64'(seg2);
      chk($sformatf("seg_bus[dut%0d]", k), got, exp_seg(k));
      chk($sformatf("active[dut%0d]", k), 64'(act[k]), 64'(m_run[k]));
      chk($sformatf("step_pulse[dut%0d]", k), 64'(stp[k]), 64'(m_step[k]));
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 1'b0; m_btn[k] = 1'b0; m_step[k] = 1'b0; m_el[k] = 0;
    end
    m_mode     = 2'b00;
    rst        = 1'b1;
    button_inp = 1'b1;
    mode       = 2'b00;
    run_cycles(2);
    rst = 1'b0;
    run_cycles(20);
    button_inp = 1'b0;
    run_cycles(3);
    mode = 2'b01;
    run_cycles(1);
    button_inp = 1'b1;
    run_cycles(40);
    mode = 2'b10;
    run_cycles(36);
    button_inp = 1'b0;
    run_cycles(2);
    button_inp = 1'b1;
    run_cycles(1);
    button_inp = 1'b0;
    run_cycles(13);
    mode = 2'b00;
    run_cycles(1);
    button_inp = 1'b1;
    run_cycles(13);
    mode = 2'b11;
    run_cycles(6);
    rst = 1'b1;
    run_cycles(1);
    rst = 1'b0;
    run_cycles(4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) button_inp = ~button_inp;
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
